led_limit: RTL and testbench
============================

LED_LIMIT -- requirements
Module: led_limit

Interface
REQ-001 Parameter NUM_CH, default 3: number of independent LED channels, legal range 1..32.
REQ-002 Parameter HOLD_STB, default 2: number of i_stb pulses that must follow an accepted change before the next change; legal range 1..255.
REQ-003 Parameter INIT_LED, default all zeros, width NUM_CH: o_led value after reset.
REQ-004 Port i_clk, input, 1: system clock (48 MHz).
REQ-005 Port i_rst_n, input, 1: synchronous reset, active-low, sampled on rising i_clk.
REQ-006 Port i_stb, input, 1: single-cycle rate strobe (46.875 kHz from the clock divider); shared by all channels.
REQ-007 Port i_led, input, NUM_CH: requested LED levels, one bit per channel.
REQ-008 Port o_led, output, NUM_CH: limited LED levels, registered.
REQ-009 Port o_busy, output, NUM_CH: per-channel hold-in-progress flag; present only under LED_LIMIT_BUSY_EN (REQ-024).

Function
REQ-010 Each channel SHALL run an identical, independent two-state machine, READY and HOLD, with a hold counter of width clog2(HOLD_STB+1).
REQ-011 In READY, when i_led[k] differs from o_led[k], the block SHALL load i_led[k] into o_led[k] on that rising edge, load the counter with HOLD_STB, and enter HOLD.
REQ-012 In READY, when i_led[k] equals o_led[k], the channel SHALL stay in READY with o_led[k] unchanged, regardless of i_stb.
REQ-013 In HOLD, each cycle with i_stb high SHALL decrement the counter by 1; o_led[k] SHALL NOT change while in HOLD.
REQ-014 When a decrement brings the counter to 0, the channel SHALL return to READY on that same edge.
REQ-015 A change SHALL be accepted no earlier than the cycle after the return to READY, so consecutive o_led[k] edges are separated by at least HOLD_STB strobes.
REQ-016 The guaranteed minimum time between output edges is (HOLD_STB-1) strobe periods plus 1 clock; the default gives at most 46.875 kHz, below the 64 kHz iCE40 LED limit.
REQ-017 Change acceptance has priority over a coincident strobe: an i_stb in the acceptance cycle SHALL NOT be counted.
REQ-018 Requests made during HOLD SHALL NOT be queued; on return to READY the channel compares against the current i_led[k] only.
  - A pulse that starts and ends within HOLD is lost.
REQ-019 Latency from a difference in READY to o_led update SHALL be exactly 1 clock; there is no combinational path from i_led to o_led.
REQ-020 Counter arithmetic SHALL never underflow: in HOLD the counter is always at least 1 before a decrement.
  - i_stb held high for several cycles counts once per cycle.
REQ-021 Simultaneous changes on several channels SHALL each be accepted in the same cycle; channels never block one another.

Reset
REQ-022 While i_rst_n is low at a rising i_clk, every channel SHALL enter READY with counter 0, o_led = INIT_LED, and o_busy = 0.
  - This applies mid-HOLD as well, with no residual hold.
REQ-023 On the first cycle after reset releases, a channel whose i_led differs from INIT_LED SHALL accept that change immediately.

Configuration
REQ-024 Macro LED_LIMIT_BUSY_EN:
  - Defined: port o_busy exists and o_busy[k] SHALL be high exactly while channel k is in HOLD, registered and updated on the same edge as the state.
  - Undefined: port o_busy and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-025 Defaults, i_stb every 1024 clocks; i_led 000 -> 001 in READY -> o_led = 001 one clock later; next change accepted only after 2 strobes.
REQ-026 HOLD_STB=3: toggle i_led[0] every clock for 5000 clocks -> o_led[0] edges spaced at least 2 strobe periods + 1 clock apart; no edge during HOLD.
REQ-027 Change and i_stb in the same cycle, HOLD_STB=2 -> hold ends on the 2nd subsequent strobe, not the 1st.
REQ-028 Drive i_led = 111 while o_led = 000 and all channels in READY; later change channel 1 only during its hold -> all three update together; channel 1's later change waits only for its own hold.
REQ-029 Pull i_rst_n low mid-HOLD with INIT_LED=101 and i_led=010 -> o_led = 101 during reset; 010 one clock after release; o_busy = 000 during reset (busy build).
REQ-030 Pulse i_led[2] high for 3 clocks during HOLD -> o_led[2] unchanged; channel returns to READY with no edge.

Source files
------------

// File: rtl/led_limit_if.sv
// led_limit_if: groups the rate strobe, requested LED levels and limited outputs.
// Ports: i_stb (strobe), i_led (requests), o_led (limited levels), o_busy (hold flags,
//        only with LED_LIMIT_BUSY_EN). master = driver side, slave = limiter side.
interface led_limit_if #(
    parameter int NUM_CH = 3
) ();
    logic              i_stb;
    logic [NUM_CH-1:0] i_led;
    logic [NUM_CH-1:0] o_led;
`ifdef LED_LIMIT_BUSY_EN
    logic [NUM_CH-1:0] o_busy;

    modport master (output i_stb, output i_led, input o_led, input o_busy);
    modport slave  (input i_stb, input i_led, output o_led, output o_busy);
`else
    modport master (output i_stb, output i_led, input o_led);
    modport slave  (input i_stb, input i_led, output o_led);
`endif
endinterface

// File: rtl/led_limit.sv
// led_limit: per-channel LED toggle-rate limiter; after an accepted change a channel
//   ignores requests until HOLD_STB rate strobes have passed.
// Latency: 1 clock from a difference seen in READY to o_led; o_led is registered.
// Backpressure: none; requests arriving during a hold are dropped, not queued.
// Ports: i_clk, i_rst_n (synchronous, active-low), bus (led_limit_if.slave).
// Optional feature macro: LED_LIMIT_BUSY_EN adds bus.o_busy (per-channel hold flag).
module led_limit #(
    parameter int                NUM_CH   = 3,
    parameter int                HOLD_STB = 2,
    parameter logic [NUM_CH-1:0] INIT_LED = '0
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    led_limit_if.slave bus
);

    localparam int CW = $clog2(HOLD_STB + 1);

    localparam logic [0:0] ST_READY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [NUM_CH-1:0]         led_q,   led_d;
    logic [NUM_CH-1:0]         state_q, state_d;
    logic [NUM_CH-1:0][CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        led_d   = led_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (state_q[k] == ST_READY) begin
                // Acceptance wins over a coincident strobe: the strobe of the
                // acceptance cycle is not counted against the hold.
                if (bus.i_led[k] != led_q[k]) begin
                    led_d[k]   = bus.i_led[k];
                    cnt_d[k]   = CW'(HOLD_STB);
                    state_d[k] = ST_HOLD;
                end
            end else begin
                // In HOLD the counter is always >= 1, so this never wraps.
                if (bus.i_stb) begin
                    cnt_d[k] = cnt_q[k] - CW'(1);
                    if (cnt_q[k] == CW'(1)) begin
                        state_d[k] = ST_READY;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            led_q   <= INIT_LED;
            state_q <= {NUM_CH{ST_READY}};
            cnt_q   <= '0;
        end else begin
            led_q   <= led_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_led = led_q;

`ifdef LED_LIMIT_BUSY_EN
    // ST_HOLD encodes as 1, so the registered state vector is the busy vector.
    assign bus.o_busy = state_q;
`endif

endmodule

// File: tb/tb_led_limit.sv
module tb_led_limit;

    localparam int         HOLD_A = 2;
    localparam logic [2:0] INIT_A = 3'b000;
    localparam int         HOLD_B = 3;
    localparam logic [2:0] INIT_B = 3'b101;
    localparam int         PER_B  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] led_a = 3'b000;
    logic [2:0] led_b = 3'b000;
    logic       stb_man = 1'b0;
    logic       stb_gen = 1'b0;
    logic       auto_en = 1'b0;
    int         period = 1024;
    logic       stb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign stb = stb_gen | stb_man;

    led_limit_if #(.NUM_CH(3)) if_a ();
    led_limit_if #(.NUM_CH(3)) if_b ();

    assign if_a.i_stb = stb;
    assign if_a.i_led = led_a;
    assign if_b.i_stb = stb;
    assign if_b.i_led = led_b;

    led_limit #(.NUM_CH(3), .HOLD_STB(HOLD_A), .INIT_LED(INIT_A)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if_a)
    );

    led_limit #(.NUM_CH(3), .HOLD_STB(HOLD_B), .INIT_LED(INIT_B)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int min);
        n_checks++;
        if (act < min) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected >= %0d", name, act, min);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Free-running strobe: one pulse every 'period' clocks while enabled.
    initial begin
        int sc;
        sc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_en) begin
                if (sc >= period - 1) begin
                    stb_gen = 1'b1;
                    sc = 0;
                end else begin
                    stb_gen = 1'b0;
                    sc++;
                end
            end else begin
                stb_gen = 1'b0;
                sc = 0;
            end
        end
    end

    int cyc = 0;
    int stb_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (stb) stb_cnt <= stb_cnt + 1;
    end

    // Reference model: a channel may change only after it has seen HOLD strobes
    // (strobe of the change cycle excluded) since its previous output edge.
    logic [2:0] exp_a, exp_b;
    int         seen_a [3];
    int         seen_b [3];
    logic       model_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_a <= INIT_A;
            exp_b <= INIT_B;
            for (int k = 0; k < 3; k++) begin
                seen_a[k] <= HOLD_A;
                seen_b[k] <= HOLD_B;
            end
            model_valid <= 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (seen_a[k] >= HOLD_A) begin
                    if (led_a[k] != exp_a[k]) begin
                        exp_a[k]  <= led_a[k];
                        seen_a[k] <= 0;
                    end
                end else if (stb) begin
                    seen_a[k] <= seen_a[k] + 1;
                end
                if (seen_b[k] >= HOLD_B) begin
                    if (led_b[k] != exp_b[k]) begin
                        exp_b[k]  <= led_b[k];
                        seen_b[k] <= 0;
                    end
                end else if (stb) begin
                    seen_b[k] <= seen_b[k] + 1;
                end
            end
        end
    end

`ifdef LED_LIMIT_BUSY_EN
    function automatic logic [2:0] busy_vec(input int s0, input int s1, input int s2, input int h);
        busy_vec = {s2 < h, s1 < h, s0 < h};
    endfunction
`endif

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model_a_led", 32'(if_a.o_led), 32'(exp_a));
            chk("model_b_led", 32'(if_b.o_led), 32'(exp_b));
`ifdef LED_LIMIT_BUSY_EN
            chk("model_a_busy", 32'(if_a.o_busy), 32'(busy_vec(seen_a[0], seen_a[1], seen_a[2], HOLD_A)));
            chk("model_b_busy", 32'(if_b.o_busy), 32'(busy_vec(seen_b[0], seen_b[1], seen_b[2], HOLD_B)));
`endif
        end
    end

    // Edge spacing on dut_b channel 0 while its request toggles every clock.
    logic mon_en = 1'b0;
    logic prev_b0 = 1'b0;
    logic have_prev = 1'b0;
    int   last_edge = 0;
    int   n_edges = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (if_b.o_led[0] != prev_b0) begin
                if (have_prev) chk_ge("edge_gap", cyc - last_edge, 2 * PER_B + 1);
                have_prev <= 1'b1;
                last_edge <= cyc;
                n_edges   <= n_edges + 1;
            end
        end else begin
            have_prev <= 1'b0;
        end
        prev_b0 <= if_b.o_led[0];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

    initial begin
        int  cnt0;
        bit  got;

        // Reset values.
        tick(2);
        chk("reset_a", 32'(if_a.o_led), 32'(3'b000));
        chk("reset_b", 32'(if_b.o_led), 32'(3'b101));
`ifdef LED_LIMIT_BUSY_EN
        chk("reset_busy_a", 32'(if_a.o_busy), 32'(3'b000));
`endif
        rst_n = 1'b1;
        tick(1);
        // dut_b requests 000 against INIT 101: accepted on the first cycle.
        chk("b_first_accept", 32'(if_b.o_led), 32'(3'b000));
        chk("a_idle", 32'(if_a.o_led), 32'(3'b000));

        // Single change, one clock latency, no combinational path.
        led_a = 3'b001;
        #1;
        chk("no_comb_path", 32'(if_a.o_led), 32'(3'b000));
        tick(1);
        chk("latency_1", 32'(if_a.o_led), 32'(3'b001));
`ifdef LED_LIMIT_BUSY_EN
        chk("busy_after_accept", 32'(if_a.o_busy), 32'(3'b001));
`endif

        // Hold needs two strobes.
        led_a = 3'b000;
        tick(3);
        chk("hold_no_stb", 32'(if_a.o_led), 32'(3'b001));
        stb_man = 1'b1; tick(1); stb_man = 1'b0; tick(2);
        chk("hold_one_stb", 32'(if_a.o_led), 32'(3'b001));
        stb_man = 1'b1; tick(1); stb_man = 1'b0;
        chk("no_edge_on_release", 32'(if_a.o_led), 32'(3'b001));
        tick(1);
        chk("accept_after_2", 32'(if_a.o_led), 32'(3'b000));

        // Change coincident with a strobe: that strobe is not counted.
        stb_man = 1'b1; tick(1); stb_man = 1'b0; tick(1);
        stb_man = 1'b1; tick(1); stb_man = 1'b0; tick(1);
        led_a = 3'b001; stb_man = 1'b1; tick(1); stb_man = 1'b0;
        chk("accept_with_stb", 32'(if_a.o_led), 32'(3'b001));
        led_a = 3'b000;
        stb_man = 1'b1; tick(1); stb_man = 1'b0; tick(2);
        chk("coincident_not_counted", 32'(if_a.o_led), 32'(3'b001));
        stb_man = 1'b1; tick(1); stb_man = 1'b0; tick(1);
        chk("release_on_2nd", 32'(if_a.o_led), 32'(3'b000));

        // Strobe held high counts once per cycle.
        stb_man = 1'b1; tick(2); stb_man = 1'b0;
        led_a = 3'b001; tick(1);
        chk("stb_held_counts", 32'(if_a.o_led), 32'(3'b001));

        // Simultaneous acceptance, then channel 1 waits only for its own hold.
        stb_man = 1'b1; tick(2); stb_man = 1'b0;
        led_a = 3'b000; tick(1);
        stb_man = 1'b1; tick(2); stb_man = 1'b0;
        led_a = 3'b111; tick(1);
        chk("all_together", 32'(if_a.o_led), 32'(3'b111));
        chk("model_pin_all", 32'(exp_a), 32'(3'b111));
        led_a = 3'b101;
        stb_man = 1'b1; tick(1); stb_man = 1'b0; tick(1);
        chk("ch1_waits", 32'(if_a.o_led), 32'(3'b111));
        stb_man = 1'b1; tick(1); stb_man = 1'b0; tick(1);
        chk("ch1_after_hold", 32'(if_a.o_led), 32'(3'b101));

        // Short pulse on channel 2 during its hold is lost.
        led_a = 3'b001; tick(1);
        chk("ch2_accept", 32'(if_a.o_led), 32'(3'b001));
        led_a = 3'b101; tick(3); led_a = 3'b001;
        chk("pulse_in_hold", 32'(if_a.o_led), 32'(3'b001));
        stb_man = 1'b1; tick(2); stb_man = 1'b0; tick(2);
        chk("pulse_lost", 32'(if_a.o_led), 32'(3'b001));

        // Reset in the middle of a hold on dut_b.
        led_a = 3'b000;
        led_b = 3'b010; tick(1);
        chk("b_accept_010", 32'(if_b.o_led), 32'(3'b010));
        rst_n = 1'b0; tick(1);
        chk("b_in_reset", 32'(if_b.o_led), 32'(3'b101));
        chk("a_in_reset", 32'(if_a.o_led), 32'(3'b000));
        chk("model_pin_reset", 32'(exp_b), 32'(3'b101));
`ifdef LED_LIMIT_BUSY_EN
        chk("b_busy_in_reset", 32'(if_b.o_busy), 32'(3'b000));
`endif
        rst_n = 1'b1; tick(1);
        chk("b_after_release", 32'(if_b.o_led), 32'(3'b010));

        // Default strobe rate: edge returns only after two strobes.
        period = 1024; auto_en = 1'b1;
        led_a = 3'b001; tick(1);
        chk("slow_accept", 32'(if_a.o_led), 32'(3'b001));
        led_a = 3'b000;
        cnt0 = stb_cnt;
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick(1);
            if (if_a.o_led[0] == 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        chk("slow_edge_seen", 32'(got), 32'(1'b1));
        chk("strobes_before_edge", 32'(stb_cnt - cnt0), 32'd2);

        // Toggle channel 0 of dut_b every clock; edges must stay spaced.
        auto_en = 1'b0; tick(1);
        period = PER_B; auto_en = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            led_b[0] = ~led_b[0];
            tick(1);
        end
        mon_en = 1'b0;
        auto_en = 1'b0;
        tick(2);
        chk_ge("edge_count", n_edges, 90);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
